viterbi_sched: RTL and testbench
================================

VITERBI_SCHED -- requirements
Module: viterbi_sched

Interface
REQ-001 SHALL have parameter BLK_BITS, default 14, meaning coded bits per decoder block (rate-1/2, 7 info bits).
REQ-002 SHALL have parameter DEC_TIMEOUT, default 32, meaning max clk cycles to wait for dec_done.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ch0_bit/ch1_bit  input  1  serial coded bit per channel.
REQ-006 SHALL have ports ch0_vld/ch1_vld  input  1  coded bit valid this cycle.
REQ-007 SHALL have port dec_start  output  1  one-cycle pulse launching the shared decoder.
REQ-008 SHALL have port dec_block  output  14  coded block to decoder, first-received bit in [0].
REQ-009 SHALL have ports dec_done  input  1 and dec_bits  input  7  decoder completion pulse and decoded bits.
REQ-010 SHALL have ports out_bits  output  7, out_ch  output  1, out_valid  output  1, out_ready  input  1  result handshake.
REQ-011 SHALL have port ovf_err  output  2  sticky per-channel overflow flag, bit n = channel n.
REQ-012 SHALL have port tmo_err  output  1  sticky decoder-timeout flag.

Function
REQ-013 Each channel SHALL own a 14-bit shift buffer and a 0..14 fill counter; a valid bit is written at index fill, then fill increments.
REQ-014 A channel SHALL raise its request when fill==14.
REQ-015 A valid bit arriving while fill==14 SHALL be dropped and SHALL set that channel's ovf_err bit; buffer contents are unchanged.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-017 IDLE: on any request, grant by round-robin (last-served channel loses a tie; after reset channel 0 wins a tie), latch the channel's buffer into dec_block, clear its fill to 0, go to ISSUE.
REQ-018 A channel whose fill is cleared in the grant cycle SHALL accept a simultaneous valid bit at index 0 (fill becomes 1).
REQ-019 ISSUE: assert dec_start for exactly one cycle, go to WAIT; dec_block SHALL stay stable from ISSUE until leaving WAIT.
REQ-020 WAIT: on dec_done, capture dec_bits into out_bits, granted channel into out_ch, set out_valid, go to OUT; dec_done in any other state SHALL be ignored.
REQ-021 OUT: hold out_bits/out_ch/out_valid until out_valid && out_ready; on that cycle clear out_valid, go to IDLE.
REQ-022 Minimum latency SHALL be: grant cycle -> dec_start next cycle -> out_valid the cycle after dec_done.
REQ-023 Back-to-back requests SHALL be served in alternation; no channel is served twice while the other is requesting.
REQ-024 Input buffering SHALL continue in all FSM states.

Reset
REQ-025 While reset is low: state=IDLE, dec_start=0, dec_block=0, out_bits=0, out_ch=0, out_valid=0, ovf_err=0, tmo_err=0, fill counters=0, buffers=0, round-robin pointer=channel 1 last served.
REQ-026 Reset asserted mid-operation SHALL abandon the in-flight block without output; a later dec_done SHALL be ignored.
REQ-027 Sticky flags SHALL clear only by reset.

Configuration
REQ-028 With macro VITERBI_SCHED_TIMEOUT_EN defined, WAIT SHALL count cycles; on reaching DEC_TIMEOUT without dec_done, set tmo_err, discard the block, return to IDLE with no out_valid.
REQ-029 Without VITERBI_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely and tmo_err SHALL be tied 0.

Verification
REQ-030 Ch0 sends 14 bits 0x3A5C (bit0 first), decoder returns 7'h2B 3 cycles after dec_start -> dec_block=14'h3A5C, single dec_start pulse, out_bits=7'h2B, out_ch=0.
REQ-031 Both channels fill in the same cycle after reset -> ch0 served first, then ch1; two outputs in order ch0, ch1.
REQ-032 Ch1 sends 15 valid bits with ch1 never granted (out_ready held 0, ch0 result pending) -> ovf_err=2'b10, ch1 buffer holds first 14 bits.
REQ-033 out_ready held low 10 cycles after out_valid -> out_bits/out_ch stable, no new dec_start; out_ready=1 -> out_valid drops next cycle.
REQ-034 Macro defined, dec_done never asserted -> tmo_err=1 exactly 32 cycles into WAIT, FSM back in IDLE, out_valid stays 0.
REQ-035 reset pulsed low in WAIT, then dec_done -> all outputs at reset values, out_valid remains 0.

Source files
------------

// File: rtl/viterbi_sched.sv
// Two-channel coded-bit collector sharing one Viterbi decoder via round-robin.
// Optional decoder watchdog enabled by defining VITERBI_SCHED_TIMEOUT_EN.
module viterbi_sched #(
   parameter int unsigned BLK_BITS    = 14,
   parameter int unsigned DEC_TIMEOUT = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ch0_bit,
   input  logic                  ch1_bit,
   input  logic                  ch0_vld,
   input  logic                  ch1_vld,
   output logic                  dec_start,
   output logic [BLK_BITS-1:0]   dec_block,
   input  logic                  dec_done,
   input  logic [BLK_BITS/2-1:0] dec_bits,
   output logic [BLK_BITS/2-1:0] out_bits,
   output logic                  out_ch,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            ovf_err,
   output logic                  tmo_err
);

`ifdef VITERBI_SCHED_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int unsigned FILL_W = $clog2(BLK_BITS + 1);
   localparam int unsigned CNT_W  = $clog2(DEC_TIMEOUT + 1);
   localparam logic [FILL_W-1:0] FULL     = FILL_W'(BLK_BITS);
   localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(DEC_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

   state_e                  state_q, state_d;
   logic [BLK_BITS-1:0]     sbuf_q [2];
   logic [BLK_BITS-1:0]     sbuf_d [2];
   logic [FILL_W-1:0]       fill_q [2];
   logic [FILL_W-1:0]       fill_d [2];
   logic                    last_q, last_d;
   logic [BLK_BITS-1:0]     dec_block_q, dec_block_d;
   logic [BLK_BITS/2-1:0]   out_bits_q, out_bits_d;
   logic                    out_ch_q, out_ch_d;
   logic                    out_valid_q, out_valid_d;
   logic [1:0]              ovf_q, ovf_d;
   logic                    tmo_q, tmo_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [1:0] ch_bit, ch_vld, req;
   logic       grant, gnt_ch;

   assign ch_bit = {ch1_bit, ch0_bit};
   assign ch_vld = {ch1_vld, ch0_vld};
   assign req    = {fill_q[1] == FULL, fill_q[0] == FULL};

   always_comb begin
      state_d     = state_q;
      sbuf_d      = sbuf_q;
      fill_d      = fill_q;
      last_d      = last_q;
      dec_block_d = dec_block_q;
      out_bits_d  = out_bits_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      tmo_d       = tmo_q;
      cnt_d       = cnt_q;
      grant       = 1'b0;
      gnt_ch      = last_q;

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               grant       = 1'b1;
               // last_q names the channel served most recently; it loses a tie
               gnt_ch      = (&req) ? ~last_q : req[1];
               last_d      = gnt_ch;
               dec_block_d = sbuf_q[gnt_ch];
               state_d     = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (dec_done) begin
               out_bits_d  = dec_bits;
               out_ch_d    = last_q;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
               tmo_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StOut: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      for (int i = 0; i < 2; i++) begin
         if (grant && (gnt_ch == 1'(i))) begin
            // buffer drained this cycle, so a concurrent bit starts the next block
            fill_d[i] = ch_vld[i] ? FILL_W'(1) : '0;
            if (ch_vld[i]) sbuf_d[i][0] = ch_bit[i];
         end else if (ch_vld[i]) begin
            if (fill_q[i] == FULL) begin
               ovf_d[i] = 1'b1;
            end else begin
               sbuf_d[i][fill_q[i]] = ch_bit[i];
               fill_d[i]            = fill_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         sbuf_q      <= '{default: '0};
         fill_q      <= '{default: '0};
         last_q      <= 1'b1;
         dec_block_q <= '0;
         out_bits_q  <= '0;
         out_ch_q    <= 1'b0;
         out_valid_q <= 1'b0;
         ovf_q       <= '0;
         tmo_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sbuf_q      <= sbuf_d;
         fill_q      <= fill_d;
         last_q      <= last_d;
         dec_block_q <= dec_block_d;
         out_bits_q  <= out_bits_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         tmo_q       <= tmo_d;
         cnt_q       <= cnt_d;
      end
   end

   assign dec_start = (state_q == StIssue);
   assign dec_block = dec_block_q;
   assign out_bits  = out_bits_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign ovf_err   = ovf_q;
   assign tmo_err   = TMO_EN & tmo_q;

endmodule

// File: tb/tb_viterbi_sched.sv
// Directed bench for viterbi_sched: arbitration, handshake, overflow, timeout, reset.
module tb_viterbi_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ch0_bit = 1'b0, ch1_bit = 1'b0, ch0_vld = 1'b0, ch1_vld = 1'b0;
   logic        dec_start;
   logic [13:0] dec_block;
   logic        dec_done = 1'b0;
   logic [6:0]  dec_bits = '0;
   logic [6:0]  out_bits;
   logic        out_ch, out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  ovf_err;
   logic        tmo_err;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int s;

   viterbi_sched #(.BLK_BITS(14), .DEC_TIMEOUT(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .ch0_bit   (ch0_bit),
      .ch1_bit   (ch1_bit),
      .ch0_vld   (ch0_vld),
      .ch1_vld   (ch1_vld),
      .dec_start (dec_start),
      .dec_block (dec_block),
      .dec_done  (dec_done),
      .dec_bits  (dec_bits),
      .out_bits  (out_bits),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf_err   (ovf_err),
      .tmo_err   (tmo_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dec_start === 1'b1) n_start++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; ch0_vld = 1'b0; ch1_vld = 1'b0; dec_done = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic send(input logic [1:0] chs, input logic [13:0] v0, input logic [13:0] v1);
      for (int i = 0; i < 14; i++) begin
         ch0_vld = chs[0]; ch0_bit = v0[i];
         ch1_vld = chs[1]; ch1_bit = v1[i];
         tick();
      end
      ch0_vld = 1'b0; ch1_vld = 1'b0;
   endtask

   task automatic finish_dec(input logic [6:0] bits);
      dec_done = 1'b1; dec_bits = bits;
      tick();
      dec_done = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] b;
      logic [14:0] v1x;
      b   = 14'h2D53;
      v1x = {1'b1, 14'h1234};

      // reset values while reset is held low
      tick(); tick();
      check("rst dec_start", 32'(dec_start), 0);
      check("rst dec_block", 32'(dec_block), 0);
      check("rst out_bits", 32'(out_bits), 0);
      check("rst out_ch", 32'(out_ch), 0);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst ovf_err", 32'(ovf_err), 0);
      check("rst tmo_err", 32'(tmo_err), 0);
      reset = 1'b1;

      // single ch0 block, decoder answers 3 cycles after dec_start
      s = n_start;
      send(2'b01, 14'h3A5C, 14'h0);
      tick();
      check("basic dec_start", 32'(dec_start), 1);
      check("basic dec_block", 32'(dec_block), 32'h3A5C);
      tick();
      check("basic start pulse low", 32'(dec_start), 0);
      tick(); tick();
      finish_dec(7'h2B);
      check("basic out_valid", 32'(out_valid), 1);
      check("basic out_bits", 32'(out_bits), 32'h2B);
      check("basic out_ch", 32'(out_ch), 0);
      check("basic start count", 32'(n_start - s), 1);
      pop();
      check("basic out_valid drop", 32'(out_valid), 0);

      // simultaneous fill after reset, then alternation while ch0 refills
      do_reset();
      send(2'b11, 14'h0F0F, 14'h2AAA);
      tick();
      check("tie ch0 first", 32'(dec_block), 32'h0F0F);
      send(2'b01, 14'h1555, 14'h0);
      finish_dec(7'h11);
      check("tie out_ch0", 32'(out_ch), 0);
      check("tie out_bits0", 32'(out_bits), 32'h11);
      pop();
      tick();
      check("alt ch1 wins", 32'(dec_block), 32'h2AAA);
      tick();
      finish_dec(7'h22);
      check("tie out_ch1", 32'(out_ch), 1);
      check("tie out_bits1", 32'(out_bits), 32'h22);
      pop();
      tick();
      check("alt ch0 next", 32'(dec_block), 32'h1555);
      check("alt dec_start", 32'(dec_start), 1);
      tick();
      finish_dec(7'h33);
      check("alt out_ch", 32'(out_ch), 0);
      pop();

      // bit arriving in the grant cycle lands at index 0 of the next block
      do_reset();
      send(2'b01, 14'h00FF, 14'h0);
      ch0_vld = 1'b1; ch0_bit = b[0];
      tick();
      for (int i = 1; i < 14; i++) begin
         ch0_bit = b[i];
         tick();
      end
      ch0_vld = 1'b0;
      finish_dec(7'h05);
      pop();
      tick();
      check("grant-cycle bit block", 32'(dec_block), 32'(b));
      check("grant-cycle no ovf", 32'(ovf_err), 0);
      tick();
      finish_dec(7'h06);
      pop();

      // ch1 overflows while ch0 result is held by out_ready low
      do_reset();
      send(2'b01, 14'h0C3C, 14'h0);
      tick(); tick();
      finish_dec(7'h5A);
      check("hold out_valid", 32'(out_valid), 1);
      s = n_start;
      for (int i = 0; i < 15; i++) begin
         ch1_vld = 1'b1; ch1_bit = v1x[i];
         tick();
      end
      ch1_vld = 1'b0;
      check("hold out_valid stable", 32'(out_valid), 1);
      check("hold out_bits stable", 32'(out_bits), 32'h5A);
      check("hold out_ch stable", 32'(out_ch), 0);
      check("hold no dec_start", 32'(n_start - s), 0);
      check("ovf ch1", 32'(ovf_err), 32'h2);
      pop();
      check("hold release", 32'(out_valid), 0);
      tick();
      check("ovf buffer intact", 32'(dec_block), 32'h1234);
      check("ovf sticky", 32'(ovf_err), 32'h2);
      tick();
      finish_dec(7'h00);
      pop();

      // decoder never answers
      do_reset();
      send(2'b01, 14'h1111, 14'h0);
      tick();
      tick();
`ifdef VITERBI_SCHED_TIMEOUT_EN
      repeat (31) tick();
      check("tmo not early", 32'(tmo_err), 0);
      tick();
      check("tmo set", 32'(tmo_err), 1);
      check("tmo no out_valid", 32'(out_valid), 0);
      finish_dec(7'h7F);
      check("tmo late done ignored", 32'(out_valid), 0);
      tick();
      check("tmo idle no start", 32'(dec_start), 0);
      check("tmo still no out_valid", 32'(out_valid), 0);
`else
      repeat (40) tick();
      check("no tmo flag", 32'(tmo_err), 0);
      check("no tmo out_valid", 32'(out_valid), 0);
      finish_dec(7'h7F);
      check("no tmo late done", 32'(out_valid), 1);
      check("no tmo out_bits", 32'(out_bits), 32'h7F);
      pop();
`endif

      // reset during WAIT abandons the block
      do_reset();
      send(2'b01, 14'h3FFF, 14'h0);
      tick();
      tick();
      s = n_start;
      reset = 1'b0;
      #2;
      check("midrst dec_block", 32'(dec_block), 0);
      check("midrst dec_start", 32'(dec_start), 0);
      tick();
      reset = 1'b1;
      finish_dec(7'h44);
      tick();
      check("midrst out_valid", 32'(out_valid), 0);
      check("midrst out_bits", 32'(out_bits), 0);
      check("midrst out_ch", 32'(out_ch), 0);
      check("midrst dec_block after", 32'(dec_block), 0);
      check("midrst no restart", 32'(n_start - s), 0);
      check("midrst ovf", 32'(ovf_err), 0);
      check("midrst tmo", 32'(tmo_err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
